uart_job_loader: RTL
====================

Name: uart_job_loader

Overview:
- Parametrised command/framing engine between a byte-level UART (rx/tx valid/ready byte interfaces) and a hashing core.
- Speaks a small command protocol, loads a job payload of configurable length with XOR-checksum validation and an inter-byte timeout, launches the core, then returns a status byte and a nonce of configurable width.
- Successor of the fixed-layout loader: payload length, nonce width and timeout are generic, and it adds abort-while-hashing, not-found reporting and error recovery.

Parameters:
- JOB_BYTES, 84, payload bytes per job (>=1).
- NONCE_BYTES, 4, nonce bytes returned on success (>=1).
- TIMEOUT_CYCLES, 1_000_000, max idle cycles between payload bytes; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- rx_valid  in  1  received byte available
- rx_data  in  8  received byte
- rx_ready  out  1  loader accepts rx byte this cycle
- tx_valid  out  1  response byte pending
- tx_data  out  8  response byte
- tx_ready  in  1  UART tx accepts byte
- job_data  out  JOB_BYTES*8  payload; byte i at [8*i +: 8]
- job_valid  out  1  one-cycle job-start pulse to core
- core_rst  out  1  active-high core reset
- core_done  in  1  core finished (level, held until core_rst)
- core_found  in  1  qualifies core_done: nonce found
- core_nonce  in  NONCE_BYTES*8  found nonce, byte 0 sent first
- busy  out  1  high in LOAD, CHECK, HASH, SEND

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; rx_ready=1, tx_valid=0, tx_data=0, job_valid=0, core_rst=1, busy=0; job_data cleared to 0.
- Byte accepted = rx_valid & rx_ready. Transmitted = tx_valid & tx_ready.
- tx holds one byte. tx_valid/tx_data stay stable until transmitted. rx_ready=0 whenever tx_valid=1, so rx and tx never collide.
- IDLE: 'H' -> send '1', core_rst=0, go READY. 'R' -> send 'O'. Any other byte -> send 'E'.
- READY:
  - 'J' -> clear byte counter and running XOR, go LOAD.
  - 'H' -> send '1'.
  - 'R' -> send 'O', core_rst=1, go IDLE.
  - Other -> send 'E'.
- LOAD:
  - Every accepted byte is raw data; command letters are not decoded.
  - Byte k writes job_data[8*k +: 8], XORs into the running checksum and increments the counter.
  - After byte JOB_BYTES-1, go CHECK.
- Timeout in LOAD: the idle counter resets on each accepted byte. When it reaches TIMEOUT_CYCLES-1 with no accepted byte, send 'T' and go READY. job_data keeps its partial contents.
- CHECK: the next accepted byte is the checksum.
  - Equal to the running XOR: send 'S', pulse job_valid for one cycle, go HASH.
  - Otherwise: send 'C', go READY.
  - The timeout also applies in CHECK.
- HASH: rx_ready=1 while no tx pending.
  - 'R' -> core_rst=1, send 'A' (abort), go IDLE.
  - Any other byte -> send 'B' (busy), ignored.
  - core_done=1 is latched into a sticky flag (core_found and core_nonce captured at the same time). Go SEND only once the flag is set and no tx is pending, so 'S' always precedes the result.
- SEND:
  - Found: send 'Y', then nonce bytes 0..NONCE_BYTES-1, each on a new byte after the previous one is transmitted.
  - Not found: send 'N' only.
  - After the last byte is transmitted: core_rst=1 for exactly one cycle, flag cleared, go READY.
  - rx_ready=0 throughout SEND.
- Simultaneous events:
  - Reset overrides everything.
  - core_done in the same cycle as an accepted 'R' in HASH: abort wins and the result is discarded.
  - A timeout and a byte accepted in the same cycle: the byte wins.
- Counters sized $clog2(JOB_BYTES+1) and $clog2(TIMEOUT_CYCLES+1). Counters saturate and never wrap.

Test Plan:
- Reset, send 'X', 'H', 'R' -> responses 'E', '1', 'O'; core_rst 1 -> 0 after 'H' -> 1 after 'R'.
- JOB_BYTES=4: send 'H','J',0x11,0x22,0x33,0x44,0x44 -> 'S'; job_data=0x44332211; job_valid is a single-cycle pulse.
- Same job, core_done=1 with core_found=1 and core_nonce=0xDEADBEEF asserted while 'S' is still pending (tx_ready=0) -> tx sequence 'S','Y',0xEF,0xBE,0xAD,0xDE; then core_rst pulses one cycle; state READY.
- Bad checksum 0x00 -> 'C', no job_valid. core_found=0 path -> 'S','N'. Payload bytes 'R','H' are loaded as data, not decoded.
- TIMEOUT_CYCLES=16: 'J', two bytes, then silence -> 'T' exactly 16 cycles after the last accepted byte; the next 'J' loads from index 0.
- 'R' during HASH concurrent with core_done -> 'A', core_rst=1, state IDLE, no 'Y'/'N'. rstn low mid-SEND -> tx_valid=0 on the next cycle.

Source files
------------

// File: rtl/uart_job_loader.sv
// Command/framing engine between a byte UART and a hashing core: loads a checksummed job,
// launches the core and streams back status plus nonce. One response byte in flight at a time.
module uart_job_loader #(
  parameter int JOB_BYTES      = 84,
  parameter int NONCE_BYTES    = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [JOB_BYTES*8-1:0]   job_data,
  output logic                     job_valid,
  output logic                     core_rst,
  input  logic                     core_done,
  input  logic                     core_found,
  input  logic [NONCE_BYTES*8-1:0] core_nonce,
  output logic                     busy
);

  localparam int CW = $clog2(JOB_BYTES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int NW = $clog2(NONCE_BYTES + 1);

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_J = 8'h4A;

  typedef enum logic [2:0] {IDLE, READY, LOAD, CHECK, HASH, SEND} state_t;

  state_t                   state;
  logic [CW-1:0]            byte_cnt;
  logic [TW-1:0]            idle_cnt;
  logic [NW-1:0]            send_idx;
  logic [7:0]               xor_q;
  logic                     done_q;
  logic                     found_q;
  logic [NONCE_BYTES*8-1:0] nonce_q;
  logic [7:0]               nonce_byte;
  logic                     rx_acc;
  logic                     timeout_hit;

  assign rx_ready    = !tx_valid && (state != SEND);
  assign busy        = (state == LOAD) || (state == CHECK) || (state == HASH) || (state == SEND);
  assign rx_acc      = rx_valid && rx_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    nonce_byte = 8'h00;
    for (int i = 0; i < NONCE_BYTES; i++) begin
      if (send_idx == NW'(i)) nonce_byte = nonce_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      job_valid <= 1'b0;
      core_rst  <= 1'b1;
      job_data  <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      send_idx  <= '0;
      xor_q     <= 8'h00;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      nonce_q   <= '0;
    end else begin
      job_valid <= 1'b0;
      if (tx_valid && tx_ready && state != SEND) tx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_acc) begin
            tx_valid <= 1'b1;
            if (rx_data == CH_H) begin
              tx_data  <= "1";
              core_rst <= 1'b0;
              state    <= READY;
            end else if (rx_data == CH_R) begin
              tx_data <= "O";
            end else begin
              tx_data <= "E";
            end
          end
        end

        READY: begin
          // Ends the one-cycle core reset pulse issued when leaving SEND.
          core_rst <= 1'b0;
          if (rx_acc) begin
            if (rx_data == CH_J) begin
              byte_cnt <= '0;
              xor_q    <= 8'h00;
              idle_cnt <= '0;
              state    <= LOAD;
            end else if (rx_data == CH_H) begin
              tx_valid <= 1'b1;
              tx_data  <= "1";
            end else if (rx_data == CH_R) begin
              tx_valid <= 1'b1;
              tx_data  <= "O";
              core_rst <= 1'b1;
              state    <= IDLE;
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= "E";
            end
          end
        end

        LOAD: begin
          if (rx_acc) begin
            for (int i = 0; i < JOB_BYTES; i++) begin
              if (byte_cnt == CW'(i)) job_data[8*i +: 8] <= rx_data;
            end
            xor_q    <= xor_q ^ rx_data;
            idle_cnt <= '0;
            if (byte_cnt != CW'(JOB_BYTES)) byte_cnt <= byte_cnt + CW'(1);
            if (byte_cnt == CW'(JOB_BYTES - 1)) state <= CHECK;
          end else if (timeout_hit) begin
            tx_valid <= 1'b1;
            tx_data  <= "T";
            state    <= READY;
          end else if (idle_cnt != {TW{1'b1}}) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        CHECK: begin
          if (rx_acc) begin
            tx_valid <= 1'b1;
            idle_cnt <= '0;
            if (rx_data == xor_q) begin
              tx_data   <= "S";
              job_valid <= 1'b1;
              done_q    <= 1'b0;
              state     <= HASH;
            end else begin
              tx_data <= "C";
              state   <= READY;
            end
          end else if (timeout_hit) begin
            tx_valid <= 1'b1;
            tx_data  <= "T";
            state    <= READY;
          end else if (idle_cnt != {TW{1'b1}}) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        HASH: begin
          // Abort takes priority over a completion arriving in the same cycle.
          if (rx_acc && rx_data == CH_R) begin
            tx_valid <= 1'b1;
            tx_data  <= "A";
            core_rst <= 1'b1;
            done_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            if (core_done && !done_q) begin
              done_q  <= 1'b1;
              found_q <= core_found;
              nonce_q <= core_nonce;
            end
            if (rx_acc) begin
              tx_valid <= 1'b1;
              tx_data  <= "B";
            end else if (done_q && !tx_valid) begin
              tx_valid <= 1'b1;
              tx_data  <= found_q ? "Y" : "N";
              send_idx <= '0;
              state    <= SEND;
            end
          end
        end

        SEND: begin
          if (tx_valid && tx_ready) begin
            if (found_q && send_idx != NW'(NONCE_BYTES)) begin
              tx_data  <= nonce_byte;
              send_idx <= send_idx + NW'(1);
            end else begin
              tx_valid <= 1'b0;
              core_rst <= 1'b1;
              done_q   <= 1'b0;
              state    <= READY;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
